axi_wr_arbiter: RTL and testbench
=================================

Name: axi_wr_arbiter

Overview:
- Single-clock N:1 write-path arbiter that sits directly downstream of the per-master AXI clock-domain-crossing transactors.
- Merges NumMasters AW/W streams onto one slave write port, one whole burst at a time.
- Prefixes each AWID with the master index and routes B responses back by that prefix.
- No buffering: the transactors' FIFOs already provide decoupling. This block adds only a grant register, a state machine and an optional beat checker.

Parameters:
- NumMasters, 4, number of upstream write ports (2..16).
- AxiBusWidth, 128, W data width in bits.
- IdWidth, `ID_W_WIDTH, per-master AWID/BID width.
- IdxWidth, $clog2(NumMasters), master-index prefix width (derived localparam).

Ports:
- clk_i  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- m_awvalid/m_awready  in/out  NumMasters  per-master AW handshake.
- m_awaddr  in  NumMasters*32  packed AW address.
- m_awid  in  NumMasters*IdWidth  packed AW ID.
- m_awlen  in  NumMasters*8  packed burst length.
- m_awsize  in  NumMasters*3  packed burst size.
- m_awburst  in  NumMasters*2  packed burst type.
- m_wvalid/m_wready  in/out  NumMasters  per-master W handshake.
- m_wdata  in  NumMasters*AxiBusWidth  packed write data.
- m_wstrb  in  NumMasters*AxiBusWidth/8  packed write strobes.
- m_wlast  in  NumMasters  per-master last beat.
- m_bvalid/m_bready  out/in  NumMasters  per-master B handshake.
- m_bid  out  IdWidth  shared BID (lower bits of s_bid).
- m_bresp  out  2  shared BRESP.
- s_awvalid/s_awready  out/in  1  slave AW handshake.
- s_awaddr, s_awlen, s_awsize, s_awburst  out  32/8/3/2  slave AW fields.
- s_awid  out  IdxWidth+IdWidth  {grant index, m_awid}.
- s_wvalid/s_wready  out/in  1  slave W handshake.
- s_wdata  out  AxiBusWidth  slave write data.
- s_wstrb  out  AxiBusWidth/8  slave write strobes.
- s_wlast  out  1  slave last beat.
- s_bvalid/s_bready  in/out  1  slave B handshake.
- s_bid  in  IdxWidth+IdWidth  slave BID.
- s_bresp  in  2  slave BRESP.
- err_o  out  1  sticky burst-length error (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (async assert, sync deassert):
  - state=ARB, grant=0, rr_ptr=0.
  - All m_*ready=0, s_awvalid=0, s_wvalid=0, err_o=0.
- State ARB:
  - If any m_awvalid is high, pick the first requester at or after rr_ptr (round-robin, wraps at NumMasters-1→0).
  - Register grant, set rr_ptr=grant+1 (mod NumMasters), go to ADDR.
  - No slave valids are driven in ARB; arbitration costs 1 cycle.
- State ADDR:
  - s_aw* = m_aw*[grant] combinationally; s_awid={grant,m_awid[grant]}.
  - m_awready[grant]=s_awready; all other m_awready=0.
  - On s_awvalid&&s_awready go to DATA.
- State DATA:
  - s_w* = m_w*[grant]; m_wready[grant]=s_wready; all other m_wready=0.
  - On s_wvalid&&s_wready&&s_wlast go to ARB.
  - A beat accepted during ADDR is not allowed: W is gated until DATA.
- Burst lock: the grant does not change until the last W beat is accepted. New AW requests wait; other masters' valids are held by AXI rules.
- Back-to-back: last-beat cycle → ARB → ADDR gives a minimum 2-cycle bubble between bursts.
- B path is independent of the state machine and purely combinational:
  - idx = s_bid[IdWidth+:IdxWidth].
  - m_bvalid[idx]=s_bvalid; s_bready=m_bready[idx].
  - m_bid=s_bid[IdWidth-1:0]; m_bresp=s_bresp.
  - If idx>=NumMasters: s_bready=1 and the response is dropped.
- Single requester: the same master is re-granted each ARB visit.
- Simultaneous requests: rr_ptr decides. Example: rr_ptr=2 with requests {0,3} → grant 3.
- Reset mid-burst: state returns to ARB immediately. Partial bursts are not completed; upstream transactors are reset together.

Optional Feature:
- Macro: AXI_WR_ARB_LEN_CHECK_EN.
- With the macro:
  - On entering DATA, load beat_cnt=awlen (latched at AW handshake).
  - Decrement on each accepted beat.
  - Set err_o=1 (sticky until reset) if wlast arrives with beat_cnt!=0, or if beat_cnt==0 on a beat without wlast.
  - On an early/missing wlast, s_wlast is forced to match the counter so the slave always sees awlen+1 beats. Excess beats are accepted and dropped; missing beats are not padded.
- Without the macro: no counter, s_wlast=m_wlast[grant], err_o tied 0.

Test Plan:
- Reset, then master 1 AW addr 0x1000 len 3 plus 4 W beats → s_awid={1,id}, 4 beats on s_w*, wlast on beat 4, state back to ARB.
- Masters 0,2,3 assert AW simultaneously from reset → grants 0,2,3 in order, each burst fully completed before the next AW appears.
- s_wready held low 5 cycles mid-burst while master 2 asserts AW → no grant change, master 2's m_awready stays 0.
- s_bvalid with s_bid={2,4'h5}, bresp=OKAY → only m_bvalid[2]=1, m_bid=5, s_bready follows m_bready[2].
- rst_n pulsed low during beat 2 of an 8-beat burst → all outputs 0 asynchronously, state=ARB, grant=0 after release.
- With AXI_WR_ARB_LEN_CHECK_EN, awlen=3 and wlast on beat 2 → err_o=1 and stays 1, s_wlast=0 on beat 2.

Source files
------------

// File: rtl/axi_wr_arbiter.sv
// rtl/axi_wr_arbiter.sv - N:1 burst-locked AXI write arbiter with ID-prefix B routing
// Optional beat-length checker enabled by AXI_WR_ARB_LEN_CHECK_EN.
`ifndef ID_W_WIDTH
`define ID_W_WIDTH 4
`endif

module axi_wr_arbiter #(
    parameter int  NumMasters  = 4,
    parameter int  AxiBusWidth = 128,
    parameter int  IdWidth     = `ID_W_WIDTH,
    localparam int IdxWidth    = $clog2(NumMasters)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n,
    input  logic [NumMasters-1:0]                 m_awvalid,
    output logic [NumMasters-1:0]                 m_awready,
    input  logic [NumMasters*32-1:0]              m_awaddr,
    input  logic [NumMasters*IdWidth-1:0]         m_awid,
    input  logic [NumMasters*8-1:0]               m_awlen,
    input  logic [NumMasters*3-1:0]               m_awsize,
    input  logic [NumMasters*2-1:0]               m_awburst,
    input  logic [NumMasters-1:0]                 m_wvalid,
    output logic [NumMasters-1:0]                 m_wready,
    input  logic [NumMasters*AxiBusWidth-1:0]     m_wdata,
    input  logic [NumMasters*AxiBusWidth/8-1:0]   m_wstrb,
    input  logic [NumMasters-1:0]                 m_wlast,
    output logic [NumMasters-1:0]                 m_bvalid,
    input  logic [NumMasters-1:0]                 m_bready,
    output logic [IdWidth-1:0]                    m_bid,
    output logic [1:0]                            m_bresp,
    output logic                                  s_awvalid,
    input  logic                                  s_awready,
    output logic [31:0]                           s_awaddr,
    output logic [7:0]                            s_awlen,
    output logic [2:0]                            s_awsize,
    output logic [1:0]                            s_awburst,
    output logic [IdxWidth+IdWidth-1:0]           s_awid,
    output logic                                  s_wvalid,
    input  logic                                  s_wready,
    output logic [AxiBusWidth-1:0]                s_wdata,
    output logic [AxiBusWidth/8-1:0]              s_wstrb,
    output logic                                  s_wlast,
    input  logic                                  s_bvalid,
    output logic                                  s_bready,
    input  logic [IdxWidth+IdWidth-1:0]           s_bid,
    input  logic [1:0]                            s_bresp,
    output logic                                  err_o
);

    typedef enum logic [1:0] {ARB, ADDR, DATA} state_t;

    state_t                state, state_nxt;
    logic [IdxWidth-1:0]   grant, rr_ptr, pick, nxt_ptr;
    logic                  pick_vld;

    // Round-robin: first requester at or after rr_ptr, wrapping at NumMasters-1.
    always_comb begin : arb_pick
        int                  cand;
        logic [IdxWidth-1:0] cidx;
        pick     = '0;
        pick_vld = 1'b0;
        cand     = 0;
        cidx     = '0;
        for (int i = 0; i < NumMasters; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NumMasters) cand = cand - NumMasters;
            cidx = IdxWidth'(cand);
            if (!pick_vld && m_awvalid[cidx]) begin
                pick_vld = 1'b1;
                pick     = cidx;
            end
        end
        nxt_ptr = (pick == IdxWidth'(NumMasters - 1)) ? '0 : pick + IdxWidth'(1);
    end

`ifdef AXI_WR_ARB_LEN_CHECK_EN
    logic [7:0] beat_cnt;
    logic       drop;
    logic       err_q;
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        m_awready = '0;
        m_wready  = '0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_wlast   = 1'b0;
        s_awaddr  = m_awaddr[grant*32 +: 32];
        s_awlen   = m_awlen[grant*8 +: 8];
        s_awsize  = m_awsize[grant*3 +: 3];
        s_awburst = m_awburst[grant*2 +: 2];
        s_awid    = {grant, m_awid[grant*IdWidth +: IdWidth]};
        s_wdata   = m_wdata[grant*AxiBusWidth +: AxiBusWidth];
        s_wstrb   = m_wstrb[grant*(AxiBusWidth/8) +: (AxiBusWidth/8)];
        case (state)
            ARB: begin
                if (pick_vld) state_nxt = ADDR;
            end
            ADDR: begin
                s_awvalid        = m_awvalid[grant];
                m_awready[grant] = s_awready;
                if (s_awvalid && s_awready) state_nxt = DATA;
            end
            DATA: begin
`ifdef AXI_WR_ARB_LEN_CHECK_EN
                // After a forced last, the master's surplus beats are swallowed here.
                if (drop) begin
                    m_wready[grant] = 1'b1;
                    if (m_wvalid[grant] && m_wlast[grant]) state_nxt = ARB;
                end else begin
                    s_wvalid        = m_wvalid[grant];
                    m_wready[grant] = s_wready;
                    s_wlast         = (beat_cnt == 8'd0);
                    if (s_wvalid && s_wready && s_wlast && m_wlast[grant]) state_nxt = ARB;
                end
`else
                s_wvalid        = m_wvalid[grant];
                m_wready[grant] = s_wready;
                s_wlast         = m_wlast[grant];
                if (s_wvalid && s_wready && s_wlast) state_nxt = ARB;
`endif
            end
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ARB;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARB && pick_vld) begin
                grant  <= pick;
                rr_ptr <= nxt_ptr;
            end
        end
    end

`ifdef AXI_WR_ARB_LEN_CHECK_EN
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            drop     <= 1'b0;
            err_q    <= 1'b0;
        end else if (state == ADDR && s_awvalid && s_awready) begin
            beat_cnt <= s_awlen;
            drop     <= 1'b0;
        end else if (state == DATA && !drop && s_wvalid && s_wready) begin
            if (m_wlast[grant] != s_wlast) err_q <= 1'b1;
            if (s_wlast) drop <= !m_wlast[grant];
            else beat_cnt <= beat_cnt - 8'd1;
        end else if (state == DATA && drop && m_wvalid[grant] && m_wlast[grant]) begin
            drop <= 1'b0;
        end
    end
`endif

    // B responses steer by the index prefix; unknown indices are sunk.
    logic [IdxWidth-1:0]      bidx;
    logic [2**IdxWidth-1:0]   idx_ok;

    always_comb begin
        for (int k = 0; k < 2**IdxWidth; k++) idx_ok[k] = (k < NumMasters);
        bidx     = s_bid[IdWidth +: IdxWidth];
        m_bvalid = '0;
        s_bready = 1'b1;
        if (idx_ok[bidx]) begin
            m_bvalid[bidx] = s_bvalid;
            s_bready       = m_bready[bidx];
        end
    end

    assign m_bid   = s_bid[IdWidth-1:0];
    assign m_bresp = s_bresp;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb/tb_axi_wr_arbiter.sv - directed self-checking bench for axi_wr_arbiter
module tb_axi_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int XW = 2;

    logic                 clk_i = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N-1:0]         m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
    logic [N-1:0]         m_bvalid, m_bready;
    logic [N*32-1:0]      m_awaddr;
    logic [N*IW-1:0]      m_awid;
    logic [N*8-1:0]       m_awlen;
    logic [N*3-1:0]       m_awsize;
    logic [N*2-1:0]       m_awburst;
    logic [N*DW-1:0]      m_wdata;
    logic [N*DW/8-1:0]    m_wstrb;
    logic [IW-1:0]        m_bid;
    logic [1:0]           m_bresp;
    logic                 s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
    logic [31:0]          s_awaddr;
    logic [7:0]           s_awlen;
    logic [2:0]           s_awsize;
    logic [1:0]           s_awburst;
    logic [XW+IW-1:0]     s_awid;
    logic [DW-1:0]        s_wdata;
    logic [DW/8-1:0]      s_wstrb;
    logic                 s_bvalid, s_bready;
    logic [XW+IW-1:0]     s_bid;
    logic [1:0]           s_bresp;
    logic                 err_o;

    int checks = 0;
    int errors = 0;

    axi_wr_arbiter #(.NumMasters(N), .AxiBusWidth(DW), .IdWidth(IW)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_awid(m_awid), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awid(s_awid),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_aw(input int m, input logic [IW-1:0] id, input logic [31:0] addr,
                          input logic [7:0] len);
        m_awvalid[m]          = 1'b1;
        m_awid[m*IW +: IW]    = id;
        m_awaddr[m*32 +: 32]  = addr;
        m_awlen[m*8 +: 8]     = len;
        m_awsize[m*3 +: 3]    = 3'd2;
        m_awburst[m*2 +: 2]   = 2'b01;
    endtask

    // Entered at a negedge in ARB with master m already requesting.
    task automatic run_burst(input int m, input logic [IW-1:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input int stall_beat, input int late_m);
        logic [N-1:0] onehot;
        onehot = N'(1 << m);
        @(posedge clk_i);
        @(negedge clk_i);
        m_wvalid[m] = 1'b1;
        m_wdata[m*DW +: DW] = {addr[15:0], 16'd0};
        m_wstrb[m*4 +: 4] = 4'hF;
        m_wlast[m] = 1'b0;
        #1;
        check("addr_awvalid", s_awvalid, 1'b1);
        check("addr_awid", s_awid, {XW'(m), id});
        check("addr_awaddr", s_awaddr, addr);
        check("addr_awlen", s_awlen, len);
        check("addr_awready", m_awready, onehot);
        check("addr_w_gated", s_wvalid, 1'b0);
        check("addr_wready_gated", m_wready, '0);
        @(posedge clk_i);
        for (int b = 0; b <= int'(len); b++) begin
            @(negedge clk_i);
            m_awvalid[m] = 1'b0;
            m_wvalid[m]  = 1'b1;
            m_wdata[m*DW +: DW] = {addr[15:0], 16'(b)};
            m_wlast[m] = (b == int'(len));
            if (b == stall_beat) begin
                if (late_m >= 0) set_aw(late_m, 4'h7, 32'h7000, 8'd0);
                s_wready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    #1;
                    check("stall_wready", m_wready, '0);
                    check("stall_awready", m_awready, '0);
                    check("stall_wvalid", s_wvalid, 1'b1);
                    @(negedge clk_i);
                end
                s_wready = 1'b1;
            end
            #1;
            check("beat_wvalid", s_wvalid, 1'b1);
            check("beat_wdata", s_wdata, {addr[15:0], 16'(b)});
            check("beat_wstrb", s_wstrb, 4'hF);
            check("beat_wlast", s_wlast, (b == int'(len)));
            check("beat_wready", m_wready, onehot);
            check("beat_awready", m_awready, '0);
            @(posedge clk_i);
        end
        @(negedge clk_i);
        m_wvalid[m] = 1'b0;
        m_wlast[m]  = 1'b0;
        #1;
        check("bubble_awvalid", s_awvalid, 1'b0);
        check("bubble_wvalid", s_wvalid, 1'b0);
    endtask

    initial begin
        m_awvalid = '0; m_awaddr = '0; m_awid = '0; m_awlen = '0; m_awsize = '0;
        m_awburst = '0; m_wvalid = '0; m_wdata = '0; m_wstrb = '0; m_wlast = '0;
        m_bready = '0; s_awready = 1'b1; s_wready = 1'b1;
        s_bvalid = 1'b0; s_bid = '0; s_bresp = '0;

        repeat (2) @(negedge clk_i);
        #1;
        check("rst_awready", m_awready, '0);
        check("rst_wready", m_wready, '0);
        check("rst_awvalid", s_awvalid, 1'b0);
        check("rst_wvalid", s_wvalid, 1'b0);
        check("rst_err", err_o, 1'b0);
        @(negedge clk_i);
        rst_n = 1'b1;

        // Single burst from master 1; leaves rr_ptr at 2.
        set_aw(1, 4'hA, 32'h1000, 8'd3);
        run_burst(1, 4'hA, 32'h1000, 8'd3, -1, -1);

        // rr_ptr=2 with requests {0,3}: 3 first, then wrap to 0.
        set_aw(0, 4'h1, 32'h2000, 8'd1);
        set_aw(3, 4'h3, 32'h3000, 8'd0);
        run_burst(3, 4'h3, 32'h3000, 8'd0, -1, -1);
        run_burst(0, 4'h1, 32'h2000, 8'd1, -1, -1);

        // Fresh reset, then masters 0,2,3 together.
        rst_n = 1'b0;
        @(negedge clk_i);
        rst_n = 1'b1;
        set_aw(0, 4'h2, 32'h0100, 8'd1);
        set_aw(2, 4'h4, 32'h0200, 8'd2);
        set_aw(3, 4'h6, 32'h0300, 8'd0);
        run_burst(0, 4'h2, 32'h0100, 8'd1, -1, -1);
        run_burst(2, 4'h4, 32'h0200, 8'd2, -1, -1);
        run_burst(3, 4'h6, 32'h0300, 8'd0, -1, -1);

        // Slave stalls mid-burst while master 2 requests; grant must hold.
        set_aw(0, 4'h9, 32'h4000, 8'd3);
        run_burst(0, 4'h9, 32'h4000, 8'd3, 1, 2);
        run_burst(2, 4'h7, 32'h7000, 8'd0, -1, -1);

        // B routing by index prefix.
        s_bvalid = 1'b1; s_bid = {2'd2, 4'h5}; s_bresp = 2'b00; m_bready = 4'b0100;
        #1;
        check("b_valid_m2", m_bvalid, 4'b0100);
        check("b_bid", m_bid, 4'h5);
        check("b_bresp", m_bresp, 2'b00);
        check("b_ready_hi", s_bready, 1'b1);
        m_bready = 4'b1011;
        #1;
        check("b_ready_lo", s_bready, 1'b0);
        s_bid = {2'd0, 4'hC}; s_bresp = 2'b10; m_bready = 4'b0001;
        #1;
        check("b_valid_m0", m_bvalid, 4'b0001);
        check("b_bid_m0", m_bid, 4'hC);
        check("b_bresp_slverr", m_bresp, 2'b10);
        check("b_ready_m0", s_bready, 1'b1);
        s_bvalid = 1'b0;
        #1;
        check("b_idle", m_bvalid, 4'b0000);

        // Async reset during beat 2 of an 8-beat burst from master 1.
        @(negedge clk_i);
        set_aw(1, 4'h2, 32'h5000, 8'd7);
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        m_awvalid[1] = 1'b0; m_wvalid[1] = 1'b1; m_wlast[1] = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        check("mid_in_data", s_wvalid, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_wvalid", s_wvalid, 1'b0);
        check("arst_wready", m_wready, '0);
        check("arst_awvalid", s_awvalid, 1'b0);
        check("arst_awready", m_awready, '0);
        @(negedge clk_i);
        rst_n = 1'b1;
        #1;
        check("post_rst_arb", s_wvalid, 1'b0);
        m_wvalid[1] = 1'b0;
        // rr_ptr back to 0: requests {0,3} must grant 0 first.
        set_aw(0, 4'h8, 32'h8000, 8'd0);
        set_aw(3, 4'hB, 32'h9000, 8'd0);
        run_burst(0, 4'h8, 32'h8000, 8'd0, -1, -1);
        run_burst(3, 4'hB, 32'h9000, 8'd0, -1, -1);

`ifdef AXI_WR_ARB_LEN_CHECK_EN
        // awlen=3 with wlast on beat 2: slave never sees the early last.
        set_aw(0, 4'h4, 32'h6000, 8'd3);
        @(posedge clk_i);
        @(posedge clk_i);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk_i);
            m_awvalid[0] = 1'b0; m_wvalid[0] = 1'b1;
            m_wlast[0] = (b == 1) || (b == 3);
            #1;
            check("len_slast", s_wlast, (b == 3));
            @(posedge clk_i);
            #1;
            if (b >= 1) check("len_err_sticky", err_o, 1'b1);
        end
        @(negedge clk_i);
        m_wvalid[0] = 1'b0; m_wlast[0] = 1'b0;
        #1;
        check("len_back_arb", s_wvalid, 1'b0);
        check("len_err_hold", err_o, 1'b1);
`else
        check("err_tied", err_o, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
